// File: rtl/out_port_bcd_seg.sv
// Shows a 32-bit output-port word as two seven-segment digits (0..99, dashes above).
// Each new value goes through a double-dabble BCD conversion. SEG_LEADING_ZERO_BLANK_EN blanks a tens digit of zero.
module out_port_bcd_seg (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] value,
  output logic [6:0]  hex_hi,
  output logic [6:0]  hex_lo,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [6:0] SegDash  = 7'b0111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SegTensZero = 7'b1111111;
`else
  localparam logic [6:0] SegTensZero = SegZero;
`endif

  state_e      state_q, state_d;
  logic [31:0] last_val_q, last_val_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [14:0] shreg_q, shreg_d;  // {tens, units, bin[6:0]}
  logic [6:0]  hex_hi_q, hex_hi_d;
  logic [6:0]  hex_lo_q, hex_lo_d;
  logic        busy_q, busy_d;
  logic        changed;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign changed = (value != last_val_q);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (changed) begin
          state_d = (value <= 32'd99) ? StConv : StDone;
        end
      end
      StConv: begin
        if (cnt_q == 3'd6) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next-state
  always_comb begin
    last_val_d = last_val_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    shreg_d    = shreg_q;
    hex_hi_d   = hex_hi_q;
    hex_lo_d   = hex_lo_q;
    unique case (state_q)
      StIdle: begin
        if (changed) begin
          last_val_d = value;
          cnt_d      = 3'd0;
          ovf_d      = (value > 32'd99);
          shreg_d    = {8'd0, value[6:0]};
        end
      end
      StConv: begin
        // Add-3 correction then shift; the dropped MSB is always zero for inputs <= 99.
        shreg_d = {dd_adj(shreg_q[14:11]), dd_adj(shreg_q[10:7]), shreg_q[6:0]} << 1;
        cnt_d   = cnt_q + 3'd1;
      end
      StDone: begin
        if (ovf_q) begin
          hex_hi_d = SegDash;
          hex_lo_d = SegDash;
        end else begin
          hex_hi_d = (shreg_q[14:11] == 4'd0) ? SegTensZero : seg_digit(shreg_q[14:11]);
          hex_lo_d = seg_digit(shreg_q[10:7]);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_val_q <= 32'd0;
      cnt_q      <= 3'd0;
      ovf_q      <= 1'b0;
      shreg_q    <= 15'd0;
      hex_hi_q   <= SegTensZero;
      hex_lo_q   <= SegZero;
      busy_q     <= 1'b0;
    end else begin
      last_val_q <= last_val_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      shreg_q    <= shreg_d;
      hex_hi_q   <= hex_hi_d;
      hex_lo_q   <= hex_lo_d;
      busy_q     <= busy_d;
    end
  end

  assign hex_hi = hex_hi_q;
  assign hex_lo = hex_lo_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_out_port_bcd_seg.sv
// Scoreboard bench for out_port_bcd_seg: a timing/value model queues expected displays,
// a negedge monitor checks busy, display holds and each update (value and cycle).
module tb_out_port_bcd_seg;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value = 32'd0;
  logic [6:0]  hex_hi, hex_lo;
  logic        busy;

  out_port_bcd_seg dut (
    .clk    (clk),
    .resetn (resetn),
    .value  (value),
    .hex_hi (hex_hi),
    .hex_lo (hex_lo),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] Dash = 7'b0111111;
  localparam logic [6:0] LoZero = 7'b1000000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TensZero = 7'b1111111;
`else
  localparam logic [6:0] TensZero = 7'b1000000;
`endif

  logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct {
    logic [6:0]  hi;
    logic [6:0]  lo;
    int unsigned due;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  logic [31:0] m_last = 32'd0;
  int          m_left = 0;

  function automatic exp_t expect_for(input logic [31:0] v, input int unsigned due);
    exp_t e;
    e.due = due;
    if (v > 32'd99) begin
      e.hi = Dash;
      e.lo = Dash;
    end else begin
      e.hi = (v / 10 == 0) ? TensZero : tbl[v / 10];
      e.lo = tbl[v % 10];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Reference model: a new value is taken when idle; display follows 8 edges later (1 for overflow).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_last = 32'd0;
      m_left = 0;
      sb.delete();
    end else begin
      cyc++;
      if (m_left > 0) begin
        m_left--;
      end else if (value != m_last) begin
        m_last = value;
        m_left = (value <= 32'd99) ? 8 : 1;
        sb.push_back(expect_for(value, cyc + m_left));
      end
    end
  end

  logic [6:0] shown_hi = TensZero;
  logic [6:0] shown_lo = LoZero;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      shown_hi  = TensZero;
      shown_lo  = LoZero;
      busy_prev = 1'b0;
      chk("reset_hex_hi", {25'd0, hex_hi}, {25'd0, TensZero});
      chk("reset_hex_lo", {25'd0, hex_lo}, {25'd0, LoZero});
      chk("reset_busy", {31'd0, busy}, 32'd0);
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      if (busy_prev && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update at cycle %0d: actual hi=%b lo=%b required none",
                   cyc, hex_hi, hex_lo);
        end else begin
          e = sb.pop_front();
          chk("update_hex_hi", {25'd0, hex_hi}, {25'd0, e.hi});
          chk("update_hex_lo", {25'd0, hex_lo}, {25'd0, e.lo});
          chk("update_cycle", cyc, e.due);
          shown_hi = e.hi;
          shown_lo = e.lo;
        end
      end else begin
        chk("hold_hex_hi", {25'd0, hex_hi}, {25'd0, shown_hi});
        chk("hold_hex_lo", {25'd0, hex_lo}, {25'd0, shown_lo});
      end
      busy_prev = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    resetn = 1'b0;
    value  = 32'd0;
    step(3);
    resetn = 1'b1;
    step(20);                         // idle at zero, no conversion
    value = 32'd47;  step(12);
    value = 32'd99;  step(12);
    value = 32'd100; step(4);         // overflow
    value = 32'd5;   step(12);        // leading-zero tens
    value = 32'd12;  step(4);
    value = 32'd34;  step(22);        // change during conversion
    value = 32'd63;  step(5);
    resetn = 1'b0;   value = 32'd0;   // abort mid-conversion
    step(2);
    resetn = 1'b1;   step(20);
    value = 32'd63;  step(12);
    value = 32'd20;  step(12);
    value = 32'd21;  step(3);
    value = 32'd20;  step(12);        // returns to last value while busy
    value = 32'd9;   step(12);
    value = 32'd10;  step(12);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      value = $urandom_range(0, 99);
      else if (r < 9) value = $urandom;
      else            value = m_last;
      step(int'($urandom_range(0, 12)));
    end
    step(20);
    chk("drain_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
